// File: rtl/mul_div_unit.sv
// Iterative RV32M divide/remainder unit: restoring shift-subtract, one quotient bit per cycle.
// Divide-by-zero and signed overflow bypass the iteration and resolve in SIGN.
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             flush,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SIGN = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state, state_next;

    logic             sel_rem;
    logic             fast;
    logic             neg_quo;
    logic             neg_rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] dvsr;
    logic [CW-1:0]    cnt;

    logic             accept;
    logic             is_signed;
    logic             sign_a;
    logic             sign_b;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic             div_zero;
    logic             overflow;
    logic             fast_c;
    logic [WIDTH-1:0] fast_val;

    logic [WIDTH:0]   rem_shift;
    logic             ge;
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] quo_final;
    logic [WIDTH-1:0] rem_final;

    assign accept    = start && ready && !flush;
    assign is_signed = !op[0];
    assign sign_a    = is_signed && dividend[WIDTH-1];
    assign sign_b    = is_signed && divisor[WIDTH-1];
    assign abs_a     = sign_a ? (~dividend + 1'b1) : dividend;
    assign abs_b     = sign_b ? (~divisor + 1'b1) : divisor;
    assign div_zero  = (divisor == '0);
    assign overflow  = is_signed && (dividend == {1'b1, {(WIDTH-1){1'b0}}})
                       && (divisor == '1);
    assign fast_c    = div_zero || overflow;

    // Fast-path answer is parked in quo so SIGN can forward it without a spare register.
    always_comb begin
        if (div_zero)
            fast_val = op[1] ? dividend : '1;
        else
            fast_val = op[1] ? '0 : {1'b1, {(WIDTH-1){1'b0}}};
    end

    // One extra bit on the shifted remainder keeps the compare exact for any divisor.
    assign rem_shift = {rem, quo[WIDTH-1]};
    assign ge        = rem_shift >= {1'b0, dvsr};
    assign rem_step  = ge ? (rem_shift[WIDTH-1:0] - dvsr) : rem_shift[WIDTH-1:0];
    assign quo_final = neg_quo ? (~quo + 1'b1) : quo;
    assign rem_final = neg_rem ? (~rem + 1'b1) : rem;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (!nRST)
            state <= IDLE;
        else
            state <= state_next;
    end

    // NOTE: default assignment first so no path through the case leaves state_next unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = fast_c ? SIGN : CALC;
            CALC: if (cnt == CW'(WIDTH-1)) state_next = SIGN;
            SIGN: state_next = DONE;
            DONE: state_next = accept ? (fast_c ? SIGN : CALC) : IDLE;
            default: state_next = IDLE;
        endcase
        if (flush)
            state_next = IDLE;
    end

    always_comb begin
        ready = (state == IDLE) || (state == DONE);
        busy  = !ready;
        done  = (state == DONE);
    end

    // NOTE: datapath registers are all cleared on reset so a restarted unit never exposes stale operands.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            sel_rem <= 1'b0;
            fast    <= 1'b0;
            neg_quo <= 1'b0;
            neg_rem <= 1'b0;
            quo     <= '0;
            rem     <= '0;
            dvsr    <= '0;
            cnt     <= '0;
            result  <= '0;
        end else if (accept) begin
            sel_rem <= op[1];
            fast    <= fast_c;
            neg_quo <= sign_a ^ sign_b;
            neg_rem <= sign_a;
            quo     <= fast_c ? fast_val : abs_a;
            rem     <= '0;
            dvsr    <= abs_b;
            cnt     <= '0;
        end else if (state == CALC && !flush) begin
            rem <= rem_step;
            quo <= {quo[WIDTH-2:0], ge};
            cnt <= cnt + 1'b1;
        end else if (state == SIGN && !flush) begin
            if (fast)
                result <= quo;
            else
                result <= sel_rem ? rem_final : quo_final;
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit: latency, signed/unsigned results,
// divide-by-zero, overflow, flush, back-to-back issue and mid-operation reset.
module tb_mul_div_unit;

    localparam logic [1:0] OP_DIV  = 2'd0;
    localparam logic [1:0] OP_DIVU = 2'd1;
    localparam logic [1:0] OP_REM  = 2'd2;
    localparam logic [1:0] OP_REMU = 2'd3;
    localparam int LAT_NORM = 33;
    localparam int LAT_FAST = 1;

    logic        clk;
    logic        nRST;
    logic        start;
    logic [1:0]  op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        flush;
    logic        ready;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int checks   = 0;
    int failures = 0;
    logic [31:0] last_exp = 32'h0;

    mul_div_unit #(.WIDTH(32)) dut (
        .CLK      (clk),
        .nRST     (nRST),
        .start    (start),
        .op       (op),
        .dividend (dividend),
        .divisor  (divisor),
        .flush    (flush),
        .ready    (ready),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a request and step through the accept edge; operands are scrambled afterwards.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        start    = 1'b1;
        op       = o;
        dividend = a;
        divisor  = b;
        tick();
        start    = 1'b0;
        dividend = 32'hDEAD_BEEF;
        divisor  = 32'h1234_5678;
    endtask

    task automatic wait_done(input string tag, input logic [31:0] exp, input int exp_lat);
        int lat;
        lat = 0;
        while (!done && lat < 100) begin
            tick();
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_res"}, result, exp);
        last_exp = exp;
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        issue(o, a, b);
        wait_done(tag, exp, exp_lat);
        tick();
        check({tag, "_pulse"}, {31'b0, done}, 32'd0);
    endtask

    task automatic no_done_for(input string tag, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (done) seen++;
        end
        check(tag, 32'(seen), 32'd0);
    endtask

    initial begin
        nRST     = 1'b0;
        start    = 1'b1;
        op       = OP_DIVU;
        dividend = 32'd100;
        divisor  = 32'd7;
        flush    = 1'b0;

        tick();
        tick();
        check("rst_ready",  {31'b0, ready}, 32'd1);
        check("rst_busy",   {31'b0, busy},  32'd0);
        check("rst_done",   {31'b0, done},  32'd0);
        check("rst_result", result,         32'd0);
        start = 1'b0;
        tick();
        nRST = 1'b1;
        tick();
        check("post_rst_ready", {31'b0, ready}, 32'd1);

        run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14, LAT_NORM);
        run_op("remu_100_7", OP_REMU, 32'd100, 32'd7, 32'd2,  LAT_NORM);
        run_op("div_m7_2",   OP_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, LAT_NORM);
        run_op("rem_m7_2",   OP_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, LAT_NORM);
        run_op("div_7_m2",   OP_DIV,  32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, LAT_NORM);
        run_op("rem_7_m2",   OP_REM,  32'd7, 32'hFFFF_FFFE, 32'd1, LAT_NORM);
        run_op("divu_max_1", OP_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, LAT_NORM);
        run_op("divu_min_m1", OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, LAT_NORM);

        run_op("div_5_0",    OP_DIV,  32'd5, 32'd0, 32'hFFFF_FFFF, LAT_FAST);
        run_op("rem_5_0",    OP_REM,  32'd5, 32'd0, 32'd5, LAT_FAST);
        run_op("divu_5_0",   OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, LAT_FAST);
        run_op("rem_m5_0",   OP_REM,  32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, LAT_FAST);
        run_op("div_ovf",    OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LAT_FAST);
        run_op("rem_ovf",    OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, LAT_FAST);

        // Flush ten cycles into a DIVU; start is held alongside flush to test priority.
        issue(OP_DIVU, 32'd1000, 32'd3);
        for (int i = 0; i < 9; i++) tick();
        flush = 1'b1;
        start = 1'b1;
        tick();
        check("flush_ready", {31'b0, ready}, 32'd1);
        check("flush_done",  {31'b0, done},  32'd0);
        tick();
        check("flush_prio_busy", {31'b0, busy}, 32'd0);
        flush = 1'b0;
        start = 1'b0;
        no_done_for("flush_no_done", 40);
        check("flush_result_held", result, last_exp);
        run_op("divu_9_3", OP_DIVU, 32'd9, 32'd3, 32'd3, LAT_NORM);

        // Back-to-back: second request presented during the DONE cycle.
        issue(OP_DIVU, 32'd100, 32'd7);
        wait_done("b2b_first", 32'd14, LAT_NORM);
        issue(OP_REMU, 32'hFFFF_FFFF, 32'd16);
        check("b2b_accept_busy", {31'b0, busy}, 32'd1);
        check("b2b_accept_done", {31'b0, done}, 32'd0);
        wait_done("b2b_second", 32'd15, LAT_NORM);
        tick();
        check("b2b_pulse", {31'b0, done}, 32'd0);

        // Reset in the middle of CALC abandons the operation.
        issue(OP_DIVU, 32'd100, 32'd7);
        for (int i = 0; i < 5; i++) tick();
        nRST = 1'b0;
        tick();
        check("midrst_ready",  {31'b0, ready}, 32'd1);
        check("midrst_busy",   {31'b0, busy},  32'd0);
        check("midrst_done",   {31'b0, done},  32'd0);
        check("midrst_result", result,         32'd0);
        nRST = 1'b1;
        no_done_for("midrst_no_done", 40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
